// File: rtl/dmx_receiver.sv
// DMX512 receiver: break/MAB detection, 250 kbaud slot framing, slot output.
// Slots are reported one per pulse with index and data held between pulses.
module dmx_receiver #(
  parameter int CLKS_PER_BIT   = 48,
  parameter int BREAK_MIN_CLKS = 1056,
  parameter int MAB_MIN_CLKS   = 96,
  parameter int NUM_SLOTS      = 513
) (
  input  logic       CLK12,
  input  logic       reset,
  input  logic       dmx_rx,
  output logic       slot_valid,
  output logic [9:0] slot_index,
  output logic [7:0] slot_data,
  output logic       packet_start,
  output logic       packet_error
);

  localparam logic [2:0] S_WAIT_BREAK = 3'd0;
  localparam logic [2:0] S_MAB        = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_START      = 3'd3;
  localparam logic [2:0] S_DATA       = 3'd4;
  localparam logic [2:0] S_STOP       = 3'd5;

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CMAX = (MAB_MIN_CLKS > CLKS_PER_BIT) ?
                        MAB_MIN_CLKS : CLKS_PER_BIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = $clog2(BREAK_MIN_CLKS + 1);

  logic          rx_m, rx_s, rx_d;
  logic [LW-1:0] low_count;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic          stop2;
  logic [7:0]    shreg;
  logic [9:0]    idx;

  logic rise, fall, brk, tick_half, tick_bit;

  assign rise      = rx_s & ~rx_d;
  assign fall      = ~rx_s & rx_d;
  assign brk       = rise && (low_count == LW'(BREAK_MIN_CLKS));
  assign tick_half = (cnt == CW'(HALF));
  assign tick_bit  = (cnt == CW'(CLKS_PER_BIT));

  always_ff @(posedge CLK12) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= dmx_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge CLK12) begin
    if (reset)
      low_count <= '0;
    else if (rx_s)
      low_count <= '0;
    else if (low_count != LW'(BREAK_MIN_CLKS))
      low_count <= low_count + 1'b1;
  end

  always_ff @(posedge CLK12) begin
    if (reset) begin
      state        <= S_WAIT_BREAK;
      cnt          <= '0;
      bit_cnt      <= '0;
      stop2        <= 1'b0;
      shreg        <= '0;
      idx          <= '0;
      slot_valid   <= 1'b0;
      slot_index   <= '0;
      slot_data    <= '0;
      packet_start <= 1'b0;
      packet_error <= 1'b0;
    end else begin
      slot_valid   <= 1'b0;
      packet_start <= 1'b0;
      packet_error <= 1'b0;
      // A completed break overrides whatever frame was in progress.
      if (brk) begin
        state <= S_MAB;
        cnt   <= CW'(1);
      end else begin
        case (state)
          S_MAB: begin
            if (fall) begin
              cnt <= CW'(1);
              if (cnt >= CW'(MAB_MIN_CLKS)) begin
                packet_start <= 1'b1;
                idx          <= '0;
                state        <= S_START;
              end else begin
                packet_error <= 1'b1;
                state        <= S_WAIT_BREAK;
              end
            end else if (cnt != CW'(MAB_MIN_CLKS)) begin
              cnt <= cnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (fall) begin
              state <= S_START;
              cnt   <= CW'(1);
            end
          end
          S_START: begin
            if (tick_half) begin
              cnt     <= CW'(1);
              bit_cnt <= '0;
              state   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_bit) begin
              cnt     <= CW'(1);
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
                stop2 <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_bit) begin
              cnt <= CW'(1);
              if (!rx_s) begin
                packet_error <= 1'b1;
                state        <= S_WAIT_BREAK;
              end else if (!stop2) begin
                stop2 <= 1'b1;
              end else begin
                slot_valid <= 1'b1;
                slot_data  <= shreg;
                slot_index <= idx;
                idx        <= idx + 1'b1;
                state      <= (idx == 10'(NUM_SLOTS - 1)) ?
                              S_WAIT_BREAK : S_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmx_receiver.sv
// Scoreboard bench for dmx_receiver with scaled bit timing.
// Expected slots are queued by the stimulus and popped by a monitor.
module tb_dmx_receiver;

  localparam int B   = 8;
  localparam int BRK = 176;
  localparam int MAB = 16;

  typedef struct {
    logic [9:0] idx;
    logic [7:0] data;
  } exp_t;

  logic       CLK12 = 1'b0;
  logic       reset;
  logic       dmx_rx;
  logic       slot_valid;
  logic [9:0] slot_index;
  logic [7:0] slot_data;
  logic       packet_start;
  logic       packet_error;

  exp_t q[$];
  exp_t e;
  int nchk = 0;
  int nerr = 0;
  int nvalid = 0;
  int nstart = 0;
  int nperr = 0;
  int last_idx = -1;
  int exp_start = 0;
  int exp_err = 0;

  always #5 CLK12 = ~CLK12;

  dmx_receiver #(
    .CLKS_PER_BIT  (B),
    .BREAK_MIN_CLKS(BRK),
    .MAB_MIN_CLKS  (MAB),
    .NUM_SLOTS     (513)
  ) dut (
    .CLK12       (CLK12),
    .reset       (reset),
    .dmx_rx      (dmx_rx),
    .slot_valid  (slot_valid),
    .slot_index  (slot_index),
    .slot_data   (slot_data),
    .packet_start(packet_start),
    .packet_error(packet_error)
  );

  // Monitor: pops the scoreboard on every slot pulse.
  initial begin
    forever begin
      @(negedge CLK12);
      if (slot_valid) begin
        nchk++;
        nvalid++;
        last_idx = int'(slot_index);
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL slot_unexpected: got idx=%0d data=0x%02h, required none",
                   slot_index, slot_data);
        end else begin
          e = q.pop_front();
          if (e.idx !== slot_index || e.data !== slot_data) begin
            nerr++;
            $display("FAIL slot_match: got idx=%0d data=0x%02h, required idx=%0d data=0x%02h",
                     slot_index, slot_data, e.idx, e.data);
          end
        end
      end
      if (packet_start) nstart++;
      if (packet_error) nperr++;
      if (slot_valid || packet_start || packet_error) begin
        nchk++;
        if (int'(slot_valid) + int'(packet_start) + int'(packet_error) > 1) begin
          nerr++;
          $display("FAIL pulse_exclusive: got sv=%0b ps=%0b pe=%0b, required one-hot",
                   slot_valid, packet_start, packet_error);
        end
      end
    end
  end

  task automatic chk_eq(input string name, input int got, input int req);
    nchk++;
    if (got != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic hold(input logic v, input int n);
    dmx_rx = v;
    repeat (n) @(negedge CLK12);
  endtask

  task automatic brk(input int nlow, input int nmab);
    hold(1'b0, nlow);
    hold(1'b1, nmab);
  endtask

  task automatic tx(input logic [7:0] b, input int idx, input bit bad_stop = 1'b0);
    if (idx >= 0) q.push_back('{10'(idx), b});
    hold(1'b0, B);
    for (int i = 0; i < 8; i++) hold(b[i], B);
    hold(1'b1, B);
    hold(!bad_stop, B);
    if (bad_stop) hold(1'b1, 2 * B);
  endtask

  task automatic checkpoint(input string name);
    repeat (30) @(negedge CLK12);
    chk_eq({name, "_starts"}, nstart, exp_start);
    chk_eq({name, "_errors"}, nperr, exp_err);
    chk_eq({name, "_pending"}, q.size(), 0);
  endtask

  task automatic chk_cleared(input string name);
    chk_eq({name, "_valid"}, int'(slot_valid), 0);
    chk_eq({name, "_index"}, int'(slot_index), 0);
    chk_eq({name, "_data"}, int'(slot_data), 0);
    chk_eq({name, "_pstart"}, int'(packet_start), 0);
    chk_eq({name, "_perr"}, int'(packet_error), 0);
  endtask

  initial begin
    int v0;
    reset  = 1'b1;
    dmx_rx = 1'b1;
    repeat (3) @(negedge CLK12);
    chk_cleared("reset");
    reset = 1'b0;
    hold(1'b1, 20);

    // Short low is not a break; following slots ignored.
    brk(160, 40);
    tx(8'h12, -1);
    tx(8'h34, -1);
    checkpoint("short_break");

    // Basic packet.
    brk(1100, 120);
    exp_start++;
    tx(8'h00, 0);
    tx(8'hFF, 1);
    tx(8'h05, 2);
    hold(1'b1, 40);
    checkpoint("basic");
    chk_eq("hold_index", int'(slot_index), 2);
    chk_eq("hold_data", int'(slot_data), 8'h05);

    // Break one cycle short, from idle: framing error only.
    brk(BRK - 1, 40);
    exp_err++;
    tx(8'h11, -1);
    checkpoint("break_min_minus1");

    // Exact minimum break and MAB.
    brk(BRK, MAB);
    exp_start++;
    tx(8'hA5, 0);
    tx(8'h3C, 1);
    checkpoint("break_mab_exact");

    // Break from idle (framing error) with too-short MAB.
    brk(1100, 8);
    exp_err += 2;
    tx(8'h77, -1);
    checkpoint("mab_short");
    brk(1100, MAB - 1);
    exp_err++;
    tx(8'h78, -1);
    checkpoint("mab_min_minus1");

    // Bad second stop bit on slot 3, then recovery.
    brk(1100, 120);
    exp_start++;
    tx(8'h10, 0);
    tx(8'h20, 1);
    tx(8'h30, 2);
    tx(8'h40, -1, 1'b1);
    exp_err++;
    tx(8'h44, -1);
    checkpoint("bad_stop");
    brk(1100, 120);
    exp_start++;
    tx(8'h99, 0);
    checkpoint("resume");

    // Short low glitch in idle, then packet continues.
    hold(1'b0, 3);
    hold(1'b1, 20);
    tx(8'h5A, 1);
    tx(8'hC3, 2);
    tx(8'h81, 3);
    tx(8'h7E, 4);
    checkpoint("glitch");

    // Reset in the middle of slot 5.
    hold(1'b0, B);
    hold(1'b1, B);
    hold(1'b0, B);
    reset = 1'b1;
    @(negedge CLK12);
    chk_cleared("mid_reset");
    dmx_rx = 1'b1;
    @(negedge CLK12);
    reset = 1'b0;
    hold(1'b1, 50);
    tx(8'h66, -1);
    checkpoint("after_reset");

    // Full packet plus extra slots.
    brk(1100, 120);
    exp_start++;
    v0 = nvalid;
    for (int i = 0; i < 513; i++) tx(8'h55, i);
    for (int i = 0; i < 20; i++) tx(8'h55, -1);
    checkpoint("full_packet");
    chk_eq("full_count", nvalid - v0, 513);
    chk_eq("full_last_idx", last_idx, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
